// File: rtl/dk_trigger_seq.sv
// rtl/dk_trigger_seq.sv - trigger-pattern sequencer driving the active-low walk_en input
module dk_trigger_seq #(
  parameter int CNT_W = 24,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             I_RST,
  input  logic             audio_clk_en,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_ticks,
  input  logic [CNT_W-1:0] low_ticks,
  input  logic [REP_W-1:0] repeats,
  output logic             trig,
  output logic             walk_en,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] reps_left
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_last;
  logic [CNT_W-1:0] lo_last;
  logic             phase_last;

  // Phase lengths are stored as len-1 so a zero length behaves as one strobe.
  assign phase_last = (state == ST_HIGH) ? (cnt == hi_last) : (cnt == lo_last);

  always_ff @(posedge clk) begin
    if (I_RST || abort) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      trig      <= 1'b0;
      walk_en   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      reps_left <= '0;
      if (I_RST) begin
        hi_last <= '0;
        lo_last <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            hi_last <= (high_ticks == '0) ? '0 : high_ticks - CNT_ONE;
            lo_last <= (low_ticks == '0) ? '0 : low_ticks - CNT_ONE;
            cnt     <= '0;
            if (repeats == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_HIGH;
              trig      <= 1'b1;
              walk_en   <= 1'b0;
              busy      <= 1'b1;
              reps_left <= repeats;
            end
          end
        end
        ST_HIGH: begin
          if (audio_clk_en) begin
            if (phase_last) begin
              state   <= ST_LOW;
              trig    <= 1'b0;
              walk_en <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ST_LOW: begin
          if (audio_clk_en) begin
            if (phase_last) begin
              cnt <= '0;
              if (reps_left == REP_ONE) begin
                state     <= ST_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                reps_left <= '0;
              end else begin
                state     <= ST_HIGH;
                trig      <= 1'b1;
                walk_en   <= 1'b0;
                reps_left <= reps_left - REP_ONE;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dk_trigger_seq.sv
// tb/tb_dk_trigger_seq.sv - randomized self-checking bench for dk_trigger_seq
module tb_dk_trigger_seq;

  logic        clk = 1'b0;
  logic        I_RST = 1'b1;
  logic        audio_clk_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] high_ticks = '0;
  logic [23:0] low_ticks = '0;
  logic [7:0]  repeats = '0;
  logic        trig;
  logic        walk_en;
  logic        busy;
  logic        done;
  logic [7:0]  reps_left;

  dk_trigger_seq #(.CNT_W(24), .REP_W(8)) dut (
    .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .start(start),
    .abort(abort), .high_ticks(high_ticks), .low_ticks(low_ticks),
    .repeats(repeats), .trig(trig), .walk_en(walk_en), .busy(busy),
    .done(done), .reps_left(reps_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference: a sequence is a list of phase lengths in strobes, high first.
  int  phase_q[$];
  bit  m_active = 0;
  bit  m_done = 0;
  int  m_idx = 0;
  int  m_reps = 0;

  always @(posedge clk) begin
    if (I_RST || abort) begin
      m_active = 0; m_done = 0; m_reps = 0; m_idx = 0;
      phase_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        if (repeats == 0) m_done = 1;
        else begin
          for (int i = 0; i < int'(repeats); i++) begin
            phase_q.push_back(high_ticks == 0 ? 1 : int'(high_ticks));
            phase_q.push_back(low_ticks == 0 ? 1 : int'(low_ticks));
          end
          m_active = 1; m_idx = 0; m_reps = int'(repeats);
        end
      end
    end else if (audio_clk_en) begin
      phase_q[0] = phase_q[0] - 1;
      if (phase_q[0] == 0) begin
        void'(phase_q.pop_front());
        m_idx++;
        if (m_idx % 2 == 0) m_reps--;
        if (phase_q.size() == 0) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  int period = 12;
  int pcnt = 0;
  int n_done = 0;
  int n_bursts = 0;
  logic prev_trig = 1'b0;

  task automatic step();
    int exp_trig;
    @(negedge clk);
    exp_trig = (m_active && (m_idx % 2 == 0)) ? 1 : 0;
    check("trig", int'(trig), exp_trig);
    check("walk_en", int'(walk_en), 1 - exp_trig);
    check("busy", int'(busy), int'(m_active));
    check("done", int'(done), int'(m_done));
    check("reps_left", int'(reps_left), m_reps);
    if (done === 1'b1) n_done++;
    if (trig === 1'b1 && prev_trig === 1'b0) n_bursts++;
    prev_trig = trig;
    start = 1'b0;
    abort = 1'b0;
    I_RST = 1'b0;
    if (period > 0) begin
      pcnt = (pcnt + 1) % period;
      audio_clk_en = (pcnt == 0);
    end else begin
      audio_clk_en = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic wait_idle();
    int budget = 5000;
    while ((m_active || m_done) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("idle_timeout", 0, 1);
    step();
  endtask

  task automatic launch(input int h, input int l, input int r);
    high_ticks = 24'(h); low_ticks = 24'(l); repeats = 8'(r);
    start = 1'b1;
    step();
  endtask

  initial begin
    step();
    I_RST = 1'b1;
    step();
    check("rst_walk_en", int'(walk_en), 1);
    check("rst_reps_left", int'(reps_left), 0);

    // Basic pattern
    period = 12; n_done = 0;
    launch(2, 3, 2);
    wait_idle();
    check("basic_done_pulses", n_done, 1);

    // Zero repeats
    n_done = 0;
    launch(5, 5, 0);
    check("zero_rep_done_t1", int'(done), 1);
    wait_idle();
    check("zero_rep_done_pulses", n_done, 1);

    // Zero-length phases
    period = 0; n_done = 0; n_bursts = 0;
    launch(0, 0, 3);
    wait_idle();
    check("zero_len_bursts", n_bursts, 3);
    check("zero_len_done", n_done, 1);

    // Abort during second HIGH, then immediate restart
    period = 4; n_done = 0;
    launch(3, 3, 4);
    for (int i = 0; i < 2000 && m_idx != 2; i++) step();
    check("abort_reached_high2", m_idx, 2);
    abort = 1'b1;
    step();
    check("abort_trig", int'(trig), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done_pulses", n_done, 0);
    launch(2, 2, 2);
    wait_idle();
    check("restart_done_pulses", n_done, 1);

    // Ignored start and input changes while busy, abort beats start in IDLE
    period = 3;
    launch(3, 2, 3);
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      high_ticks = 24'($urandom_range(0, 9));
      repeats = 8'($urandom_range(0, 9));
      step();
    end
    wait_idle();
    abort = 1'b1;
    launch(2, 2, 2);
    check("abort_start_idle_busy", int'(busy), 0);

    // Reset during LOW, then restart; 8 bursts with high=1, low=6
    period = 5;
    launch(2, 4, 3);
    for (int i = 0; i < 2000 && m_idx != 1; i++) step();
    I_RST = 1'b1;
    step();
    check("rst_mid_walk_en", int'(walk_en), 1);
    n_bursts = 0; n_done = 0;
    launch(1, 6, 8);
    wait_idle();
    check("walk_bursts", n_bursts, 8);
    check("walk_done", n_done, 1);

    // Randomized sequences with occasional aborts
    for (int s = 0; s < 30; s++) begin
      period = $urandom_range(0, 4);
      launch($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) step();
        abort = 1'b1;
        step();
      end
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dk_trigger_seq.md
# dk_trigger_seq

Hardware trigger sequencer that drives the active-low `walk_en` trigger input of `dk_walk` (or any discrete sound block with the same trigger interface). It generates a programmable pattern of trigger-high / trigger-low phases, timed in audio sample ticks (`audio_clk_en`), repeated N times. It is the on-chip initiator side of the trigger interface, used for self-test and attract-mode sound playback, and replaces CPU-latch-driven triggers when enabled.

## Interface

Parameters:
- `CNT_W`, 24: width of the phase-length counters, in audio ticks.
- `REP_W`, 8: width of the repeat counter.

Ports:
- `clk`  in  1  system clock, same domain as `dk_walk`.
- `I_RST`  in  1  synchronous, active-high reset.
- `audio_clk_en`  in  1  one-cycle sample-tick strobe, shared with the sound blocks.
- `start`  in  1  request to run a sequence; sampled only in IDLE.
- `abort`  in  1  synchronous stop; highest priority after reset.
- `high_ticks`  in  CNT_W  trigger-asserted length per repeat, in audio ticks.
- `low_ticks`  in  CNT_W  trigger-released length per repeat, in audio ticks.
- `repeats`  in  REP_W  number of high+low periods.
- `trig`  out  1  active-high trigger, registered.
- `walk_en`  out  1  `~trig`, registered; connects directly to `dk_walk.walk_en`.
- `busy`  out  1  high in HIGH and LOW states.
- `done`  out  1  one-cycle pulse at normal sequence completion.
- `reps_left`  out  REP_W  remaining periods, including the current one.

## Operation

- Clock is `clk`. `I_RST` is synchronous and active-high.
- Reset values: state IDLE, `trig`=0, `walk_en`=1, `busy`=0, `done`=0, `reps_left`=0, internal counters 0.
- States are IDLE, HIGH, LOW and DONE.
- **IDLE.** When `start`=1, latch `high_ticks`, `low_ticks` and `repeats`.
  - If `repeats`==0: go to DONE. No trigger is emitted.
  - Otherwise: go to HIGH, tick counter=0, `reps_left`=`repeats`.
- **HIGH.** `trig`=1 and `busy`=1.
  - The tick counter increments on each cycle with `audio_clk_en`=1.
  - On the `audio_clk_en` cycle where counter == len−1, go to LOW and set counter=0. `len` is the latched `high_ticks`, with 0 treated as 1.
- **LOW.** `trig`=0 and `busy`=1. Ticks are counted the same way against `low_ticks`, with 0 treated as 1.
  - On the final tick, if `reps_left`==1: go to DONE and set `reps_left`=0.
  - Otherwise: decrement `reps_left`, go to HIGH, counter=0.
- **DONE.** `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `start` is ignored outside IDLE. Input changes after the latch have no effect on a running sequence.
- `abort`=1 in any state: next edge goes to IDLE, `trig`=0, `reps_left`=0, no `done` pulse. If `abort` and `start` are both high in IDLE, `abort` wins and nothing starts.
- Counter arithmetic is unsigned CNT_W bits. A comparison against len−1 never wraps, because len is at least 1.

## Timing

- All outputs are registered. `trig`, `walk_en`, `busy` and `reps_left` change on the edge that changes state.
- `start` in cycle t (IDLE): `trig`=1 and `busy`=1 from cycle t+1.
- The HIGH phase covers exactly `high_ticks` `audio_clk_en` strobes, counted from the first strobe after entry. That is the strobe count, not a cycle count.
- HIGH→LOW occurs on the edge that samples the final strobe. LOW behaves the same way.
- With `repeats`==0, `done` is high in cycle t+1 and the block is in IDLE at t+2.
- `start` sampled in the same cycle that `done` is high is ignored, because the state is DONE. The earliest restart is the first IDLE cycle.
- `I_RST` mid-sequence: the next edge applies reset values; `trig` drops in the same cycle.

## Test plan

- **Basic pattern.** `audio_clk_en` every 12 cycles; `high_ticks`=2, `low_ticks`=3, `repeats`=2, pulse `start`.
  - Expect `trig` high for 2 strobes, low for 3, high for 2, low for 3.
  - Expect exactly one `done` pulse, `reps_left` stepping 2→1→0, and `walk_en`==~`trig` throughout.
- **Zero repeats.** `repeats`=0 with `start`: `trig` stays 0, `done` is high at t+1, `busy` stays 0.
- **Zero-length phases.** `high_ticks`=0, `low_ticks`=0, `repeats`=3: each phase lasts 1 strobe; 6 alternating strobes, then `done`.
- **Abort.** Assert `abort` during the second HIGH of a `repeats`=4 run.
  - Next cycle: `trig`=0, `busy`=0, `reps_left`=0. No `done` pulse.
  - A new `start` one cycle later runs a full sequence.
- **Ignored inputs.** Pulse `start` while busy and change `high_ticks` mid-run: the timing of the running sequence is unchanged. `abort`+`start` together in IDLE: nothing starts.
- **Reset.** `I_RST` during LOW: next cycle all outputs are at reset values (`walk_en`=1). After release, `start` runs normally. Chain into `dk_walk` with `high_ticks`=1, `low_ticks`=6, `repeats`=8 and check for 8 nonzero walk bursts on `out`.
